// File: rtl/param_seq_detector.sv
// Serial pattern detector with a runtime-loadable PAT_LEN-bit pattern, optional overlap,
// a wrapping match counter and a 7-segment digit showing the counter's low nibble.
module param_seq_detector #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               pat_load,
  input  logic               overlap_en,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [7:0]         seg
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  generate
    if (PAT_LEN < 2 || PAT_LEN > 8) begin : g_bad_pat_len
      $error("param_seq_detector: PAT_LEN must be in 2..8");
    end
    if (CNT_W < 4 || CNT_W > 16) begin : g_bad_cnt_w
      $error("param_seq_detector: CNT_W must be in 4..16");
    end
  endgenerate

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic [PAT_LEN-1:0] pat_q,   pat_d;
  logic [PAT_LEN-1:0] hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [6:0]         glyph_q, glyph_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], bit_in};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // A load in the same cycle drops the incoming bit, so it can never complete a match.
    hit        = bit_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pat_q);

    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = hit;
    glyph_d = hex_glyph(cnt_q[3:0]);

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      if (hit && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '1;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      glyph_q <= 7'h3F;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      glyph_q <= glyph_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign seg       = {match_q, glyph_q};

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed-vector bench for param_seq_detector (PAT_LEN=4, CNT_W=4).
module tb_param_seq_detector;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [3:0] pat_in;
  logic       pat_load;
  logic       overlap_en;
  logic       cnt_clr;
  logic       match;
  logic [3:0] match_cnt;
  logic [7:0] seg;

  int vectors;
  int miscompares;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  param_seq_detector #(.PAT_LEN(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .pat_in    (pat_in),
    .pat_load  (pat_load),
    .overlap_en(overlap_en),
    .cnt_clr   (cnt_clr),
    .match     (match),
    .match_cnt (match_cnt),
    .seg       (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] s1;
    logic       t3_bit [8];
    logic       t3_vld [8];
    logic       t3_exp [8];
    int         c_now;
    int         c_prev;

    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; pat_in = 4'b0;
    pat_load = 1'b0; overlap_en = 1'b0; cnt_clr = 1'b0;

    step(0, 0);
    step(0, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_seg", seg, 8'h3F);
    rst = 1'b0;

    // 1: overlapping detection of 0110 in 0110110
    overlap_en = 1'b1; pat_in = 4'b0110; pat_load = 1'b1;
    step(0, 0);
    pat_load = 1'b0;
    s1 = 7'b0110110;
    for (int i = 0; i < 7; i++) begin
      step(s1[6-i], 1);
      chk($sformatf("t1_match_bit%0d", i + 1), match, (i == 3 || i == 6) ? 1 : 0);
    end
    chk("t1_cnt", match_cnt, 2);
    step(0, 0);
    chk("t1_seg", seg, 8'h5B);

    // 2: same stream, non-overlapping
    overlap_en = 1'b0; cnt_clr = 1'b1; pat_load = 1'b1;
    step(0, 0);
    cnt_clr = 1'b0; pat_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(s1[6-i], 1);
      chk($sformatf("t2_match_bit%0d", i + 1), match, (i == 3) ? 1 : 0);
    end
    chk("t2_cnt", match_cnt, 1);
    step(0, 0);
    chk("t2_seg", seg, 8'h06);

    // 3: pattern 1011 with bubbles between accepted bits
    overlap_en = 1'b1; pat_in = 4'b1011; pat_load = 1'b1; cnt_clr = 1'b1;
    step(0, 0);
    pat_load = 1'b0; cnt_clr = 1'b0;
    t3_bit = '{1, 1, 0, 0, 1, 0, 1, 1};
    t3_vld = '{1, 0, 1, 0, 1, 0, 1, 0};
    t3_exp = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      step(t3_bit[i], t3_vld[i]);
      chk($sformatf("t3_match_cyc%0d", i), match, t3_exp[i]);
    end
    chk("t3_cnt", match_cnt, 1);

    // 4: load mid-pattern; the bit presented with the load is dropped
    step(1, 1); chk("t4_pre1", match, 0);
    step(0, 1); chk("t4_pre2", match, 0);
    step(1, 1); chk("t4_pre3", match, 0);
    pat_in = 4'b0000; pat_load = 1'b1;
    step(0, 1);
    chk("t4_load_match", match, 0);
    pat_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1);
      chk($sformatf("t4_match_bit%0d", i + 1), match, (i == 3) ? 1 : 0);
    end
    chk("t4_cnt", match_cnt, 2);

    // 5: 17 overlapping matches of 0000 wrap the 4-bit counter
    pat_in = 4'b0000; pat_load = 1'b1; cnt_clr = 1'b1;
    step(0, 0);
    pat_load = 1'b0; cnt_clr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 1);
      c_now  = (k >= 4) ? ((k - 3) % 16) : 0;
      c_prev = (k >= 5) ? ((k - 4) % 16) : 0;
      chk($sformatf("t5_match_k%0d", k), match, (k >= 4) ? 1 : 0);
      chk($sformatf("t5_cnt_k%0d", k), match_cnt, c_now);
      chk($sformatf("t5_seg_k%0d", k), seg, {((k >= 4) ? 1'b1 : 1'b0), glyph_tab[c_prev]});
    end
    step(0, 0);
    chk("t5_seg_final", seg, 8'h06);
    cnt_clr = 1'b1;
    step(0, 1);
    cnt_clr = 1'b0;
    chk("t5_clr_match", match, 1);
    chk("t5_clr_cnt", match_cnt, 0);

    // 6: reset mid-pattern restores the all-ones pattern
    overlap_en = 1'b0; pat_in = 4'b0000; pat_load = 1'b1;
    step(0, 0);
    pat_load = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 1);
    chk("t6_pre_match", match, 1);
    chk("t6_pre_cnt", match_cnt, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    rst = 1'b1;
    step(0, 1);
    chk("t6_rst_match", match, 0);
    chk("t6_rst_cnt", match_cnt, 0);
    chk("t6_rst_seg", seg, 8'h3F);
    rst = 1'b0;
    step(0, 1);
    chk("t6_fourth_bit", match, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1);
      chk($sformatf("t6_ones%0d", i + 1), match, 0);
    end
    step(1, 1);
    chk("t6_ones_match", match, 1);
    chk("t6_ones_cnt", match_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
